// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the stopwatch display block: converter
// FSM states, clamp limits and active-low 7-segment patterns (g..a).
package stopwatch_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int SHIFT_CYCLES = 7;
    localparam int MIN_MAX      = 99;
    localparam int SEC_MAX      = 59;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // BCD digit to segment pattern; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd_seq.sv
// Sequential double-dabble: 7-bit binary (0..99) to two BCD nibbles.
// The parent loads the value, then pulses en once per shift step; after
// seven steps tens/ones hold the result until the next load.
module bin2bcd_seq
    import stopwatch_display_pkg::*;
(
    input  logic       clk,
    input  logic       load,
    input  logic       en,
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // {tens, ones, remaining binary bits}
    logic [14:0] sr_p0;

    // One double-dabble step: bias nibbles >= 5 by 3, then shift left.
    function automatic logic [14:0] dabble_step(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    // Shift register: load clears the BCD accumulators, en advances one step.
    always_ff @(posedge clk) begin
        if (load) begin
            sr_p0 <= {8'd0, bin};
        end else if (en) begin
            sr_p0 <= dabble_step(sr_p0);
        end
    end

    assign tens = sr_p0[14:11];
    assign ones = sr_p0[10:7];

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display: converts a binary minutes/seconds pair to BCD with a
// sequential double-dabble and scans it onto a 4-digit active-low
// common-anode 7-segment display as MM.SS.
// Optional build macro STOPWATCH_DISPLAY_DP_BLINK_EN: the MM.SS decimal
// point toggles whenever a commit changes the seconds-ones digit.
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd,
    input  logic [6:0] min,
    input  logic [5:0] sec,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Saturate minutes to the two-digit display range.
    function automatic logic [6:0] clamp_min(input logic [6:0] m);
        return (m > 7'(MIN_MAX)) ? 7'(MIN_MAX) : m;
    endfunction

    // Saturate seconds and zero-extend to the converter width.
    function automatic logic [6:0] clamp_sec(input logic [5:0] s);
        return ({1'b0, s} > 7'(SEC_MAX)) ? 7'(SEC_MAX) : {1'b0, s};
    endfunction

    state_t      state;
    logic [2:0]  shift_cnt;
    logic        pending;
    logic [6:0]  pend_min;
    logic [6:0]  pend_sec;
    logic        load;
    logic        step_en;
    logic [6:0]  ld_min;
    logic [6:0]  ld_sec;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0][3:0] digits;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]  scan_idx;
    logic [3:0]  cur_digit;
    logic        dp_lit;

    // Capture source: live inputs from IDLE or the COMMIT cycle, else the
    // pending snapshot; a strobe in COMMIT is newer than anything pending.
    always_comb begin
        load   = 1'b0;
        ld_min = clamp_min(min);
        ld_sec = clamp_sec(sec);
        if (state == IDLE && upd) begin
            load = 1'b1;
        end else if (state == COMMIT && (upd || pending)) begin
            load = 1'b1;
            if (!upd) begin
                ld_min = pend_min;
                ld_sec = pend_sec;
            end
        end
    end

    assign step_en = (state == SHIFT);
    assign busy    = (state != IDLE);

    bin2bcd_seq u_min_bcd (
        .clk  (clk),
        .load (load),
        .en   (step_en),
        .bin  (ld_min),
        .tens (min_tens),
        .ones (min_ones)
    );

    bin2bcd_seq u_sec_bcd (
        .clk  (clk),
        .load (load),
        .en   (step_en),
        .bin  (ld_sec),
        .tens (sec_tens),
        .ones (sec_ones)
    );

    // Converter FSM: IDLE -> SHIFT (7 steps) -> COMMIT -> IDLE or back to SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= SHIFT;
                        shift_cnt <= 3'd0;
                    end
                end
                SHIFT: begin
                    if (shift_cnt == 3'(SHIFT_CYCLES - 1)) begin
                        state <= COMMIT;
                    end else begin
                        shift_cnt <= shift_cnt + 3'd1;
                    end
                end
                COMMIT: begin
                    shift_cnt <= 3'd0;
                    state     <= load ? SHIFT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending flag: set by a strobe during a conversion, consumed in COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (state == COMMIT) begin
            pending <= 1'b0;
        end else if (upd && state != IDLE) begin
            pending <= 1'b1;
        end
    end

    // Pending snapshot: last strobe while busy wins.
    always_ff @(posedge clk) begin
        if (upd && state != IDLE) begin
            pend_min <= clamp_min(min);
            pend_sec <= clamp_sec(sec);
        end
    end

    // Commit all four digits at once and flag it for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (state == COMMIT) begin
                digits <= {min_tens, min_ones, sec_tens, sec_ones};
            end
        end
    end

`ifdef STOPWATCH_DISPLAY_DP_BLINK_EN
    logic dp_phase;

    // Blink phase flips whenever a commit changes the seconds-ones digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_phase <= 1'b1;
        end else if (state == COMMIT && sec_ones != digits[0]) begin
            dp_phase <= ~dp_phase;
        end
    end

    assign dp_lit = dp_phase;
`else
    assign dp_lit = 1'b1;
`endif

    // Free-running refresh divider and digit scan index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign cur_digit = digits[scan_idx];

    // ---- scan index -> registered display pins ----
    // Anode, segment and decimal-point pins register together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= SEG_0;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << scan_idx);
            seg <= seg_encode(cur_digit);
            dp  <= (scan_idx == 2'd2) ? ~dp_lit : 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display with a decimal reference model.
module tb_stopwatch_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       upd = 1'b0;
    logic [6:0] min = '0;
    logic [5:0] sec = '0;
    logic       busy, done, dp;
    logic [6:0] seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    // Reference model: displayed decimal digits (0=sec ones .. 3=min tens).
    int md[4];
    int phase;

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    stopwatch_display #(.REFRESH_DIV(RD)) dut (
        .clk  (clk),
        .rst  (rst),
        .upd  (upd),
        .min  (min),
        .sec  (sec),
        .busy (busy),
        .done (done),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_dp(input int i);
        if (i != 2) return 1;
`ifdef STOPWATCH_DISPLAY_DP_BLINK_EN
        return (phase != 0) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) md[i] = 0;
        phase = 1;
    endfunction

    function automatic void model_commit(input int m, input int s);
        int cm, cs;
        cm = (m > 99) ? 99 : m;
        cs = (s > 59) ? 59 : s;
        if ((cs % 10) != md[0]) phase = 1 - phase;
        md[0] = cs % 10;
        md[1] = cs / 10;
        md[2] = cm % 10;
        md[3] = cm / 10;
    endfunction

    // Walk one full scan starting at the seconds-ones digit.
    task automatic check_display(input string tag);
        int n;
        logic [3:0] ea;
        n = 0;
        @(negedge clk);
        while (an !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (RD) @(negedge clk);
            ea = ~(4'b0001 << i);
            chk($sformatf("%s.an%0d", tag, i), an, ea);
            chk($sformatf("%s.seg%0d", tag, i), seg, segtab[md[i]]);
            chk($sformatf("%s.dp%0d", tag, i), dp, exp_dp(i));
        end
    endtask

    // Check whichever digit is currently enabled.
    task automatic check_current(input string tag);
        int ci;
        logic [3:0] ea;
        ci = 0;
        for (int i = 0; i < 4; i++) begin
            ea = ~(4'b0001 << i);
            if (an === ea) ci = i;
        end
        ea = ~(4'b0001 << ci);
        chk({tag, ".an"}, an, ea);
        chk({tag, ".seg"}, seg, segtab[md[ci]]);
        chk({tag, ".dp"}, dp, exp_dp(ci));
    endtask

    // Single isolated conversion with latency, busy-width and pulse checks.
    task automatic convert(input int m, input int s, input string tag);
        int n, bc;
        @(negedge clk);
        min = 7'(m);
        sec = 6'(s);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        n  = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        chk({tag, ".latency"}, n, 9);
        chk({tag, ".busy_len"}, bc, 8);
        chk({tag, ".busy_at_done"}, busy, 0);
        model_commit(m, s);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 0);
        check_display(tag);
    endtask

    initial begin
        int n, dcount, first_done, second_done;
        model_reset();

        // Reset state while held in reset.
        repeat (3) @(negedge clk);
        chk("rst.an", an, 4'b1110);
        chk("rst.seg", seg, 7'b1000000);
        chk("rst.dp", dp, 1);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        rst = 1'b0;
        check_display("idle");

        // Basic conversion.
        convert(12, 34, "basic");

        // Clamp and boundaries.
        convert(127, 63, "clampmax");
        convert(0, 0, "zero");
        convert(100, 60, "clampedge");
        convert(99, 59, "maxval");

        // Back-to-back strobes: second one superseded by the third.
        @(negedge clk);
        min = 7'd5; sec = 6'd7; upd = 1'b1;
        dcount = 0; first_done = 0; second_done = 0;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    first_done = n;
                    model_commit(5, 7);
                end else if (dcount == 2) begin
                    second_done = n;
                    model_commit(1, 2);
                end
            end
            if (n <= 16) chk($sformatf("b2b.busy%0d", n), busy, 1);
            if (n >= 10 && n <= 15) check_current($sformatf("b2b.first%0d", n));
            upd = 1'b0;
            if (n == 2) begin min = 7'd8; sec = 6'd9; upd = 1'b1; end
            if (n == 4) begin min = 7'd1; sec = 6'd2; upd = 1'b1; end
        end
        chk("b2b.done_count", dcount, 2);
        chk("b2b.first_done", first_done, 9);
        chk("b2b.second_done", second_done, 17);
        chk("b2b.busy_end", busy, 0);
        check_display("b2b");

        // Asynchronous reset mid-scan and mid-conversion.
        n = 0;
        @(negedge clk);
        while (an !== 4'b1101 && n < 20) begin
            @(negedge clk);
            n++;
        end
        min = 7'd77; sec = 6'd11; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.an", an, 4'b1110);
        chk("arst.seg", seg, 7'b1000000);
        chk("arst.dp", dp, 1);
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("arst.no_done", dcount, 0);
        check_display("arst.zero");
        convert(42, 0, "after_rst");

        // Decimal-point sequence on seconds-ones 0,1,1,2.
        convert(3, 0, "dp0");
        convert(3, 1, "dp1");
        convert(3, 1, "dp2");
        convert(3, 2, "dp3");

        // Randomized conversions against the decimal model.
        for (int r = 0; r < 6; r++) begin
            convert(int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                    $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
